point_double_chain: RTL and testbench
=====================================

POINT_DOUBLE_CHAIN -- requirements
Module: point_double_chain

Interface
REQ-001 SHALL have parameter K_WIDTH, default 4, width of the doubling-count input.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, which indicates that P and k are presented.
REQ-005 SHALL have port in_ready, output, 1, which indicates that the block accepts a new job this cycle.
REQ-006 SHALL have port P, input, curve_point_t, the affine base point.
REQ-007 SHALL have port k, input, K_WIDTH, the number of successive doublings.
REQ-008 SHALL have port out_valid, output, 1, which indicates that R holds the result.
REQ-009 SHALL have port out_ready, input, 1, the consumer acceptance signal.
REQ-010 SHALL have port R, output, curve_point_t, the result (2^k)*P.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL accept a job on the edge where in_valid and in_ready are both high, registering P into acc and k into cnt.
REQ-013 SHALL assert in_ready only in state IDLE.
REQ-014 SHALL implement the states IDLE, KICK, WAIT and OUT.
REQ-015 Transitions from IDLE on acceptance SHALL be: to KICK if k!=0, else to OUT.
REQ-016 In KICK, the block SHALL hold dbl_reset high to the doubler for exactly one cycle, then go to WAIT.
REQ-017 In WAIT, on doubler Done: acc <= doubler R and cnt <= cnt-1; then to KICK if cnt-1!=0, else to OUT.
REQ-018 Doubler Done SHALL be ignored in KICK and in the first WAIT cycle after it.
REQ-019 The doubler's P input SHALL be driven from acc and SHALL be stable from KICK until Done.
REQ-020 In OUT, out_valid SHALL be 1 and R SHALL equal acc.
REQ-021 In OUT, R and out_valid SHALL hold unchanged while out_ready=0.
REQ-022 On out_valid and out_ready both high, the block SHALL return to IDLE; in_ready SHALL rise the next cycle.
REQ-023 Latency SHALL be 1 cycle from acceptance to out_valid for k=0.
REQ-024 For k>=1, latency SHALL be k*(L+2)+1 cycles, where L is the doubler latency in cycles from its reset release to Done.
REQ-025 cnt SHALL never wrap: k=2^K_WIDTH-1 performs exactly that many doublings.
REQ-026 in_valid SHALL be ignored while busy; P and k may change freely while busy.

Reset
REQ-027 Reset SHALL force state IDLE, in_ready=1, out_valid=0, busy=0, R=0, acc=0, cnt=0 on the next edge, in any state.
REQ-028 Reset in KICK or WAIT SHALL discard the job, with no out_valid.
REQ-029 Reset SHALL also hold the doubler in reset.

Configuration
REQ-030 Macro POINT_INF_CHECK_EN SHALL select infinity handling.
REQ-031 With POINT_INF_CHECK_EN defined, the point (0,0) SHALL denote infinity.
REQ-032 With POINT_INF_CHECK_EN defined, on entering KICK with acc.y==0 the block SHALL set acc=(0,0) and go directly to OUT without kicking the doubler.
REQ-033 With POINT_INF_CHECK_EN defined, an input P=(0,0) with any k SHALL produce R=(0,0) with 1-cycle latency.
REQ-034 Without POINT_INF_CHECK_EN, no check SHALL be made; behaviour for y==0 operands is undefined, and callers guarantee y!=0.

Structure
REQ-035 curve_point_t, P_WIDTH and the state enum type SHALL live in package elliptic_curve_structs.
REQ-036 The block SHALL instantiate exactly one point_double sub-module: clk to clk, Reset to (Reset | dbl_reset), P to acc, Done and R to the FSM.
REQ-037 The block SHALL contain no other arithmetic.

Verification
REQ-038 Test k=0: P=G, k=0 -> R==G and out_valid exactly 1 cycle after acceptance; doubler never kicked.
REQ-039 Test k=3: P=G, k=3 -> R==8G per software model, exactly 3 dbl_reset pulses, latency 3*(L+2)+1.
REQ-040 Test backpressure: out_ready held 0 for 5 cycles in OUT -> R and out_valid stable, in_ready=0; accepted on cycle 6, in_ready=1 on cycle 7.
REQ-041 Test reset mid-operation: Reset in the 2nd WAIT cycle of a k=2 job -> next cycle IDLE, out_valid=0, R=0; a following job with P=G, k=1 gives R==2G.
REQ-042 Test infinity input, with POINT_INF_CHECK_EN: P=(0,0), k=5 -> R=(0,0) after 1 cycle, zero kicks.
REQ-043 Test back-to-back jobs: in_valid held high continuously with jobs (G,1) then (2G,2) -> results 2G then 8G in order, no job lost or duplicated.

Source files
------------

// File: rtl/elliptic_curve_structs.sv
// Shared curve types and GF(p) helpers for the point-doubling datapath.
// Curve: y^2 = x^3 + a*x + b over GF(251), a = 2 (b never enters doubling).
package elliptic_curve_structs;

    localparam int unsigned P_WIDTH = 8;
    localparam logic [P_WIDTH-1:0] P_MOD = 8'd251;
    localparam logic [P_WIDTH-1:0] CURVE_A = 8'd2;

    // Inverse by Fermat: z^-1 = z^(p-2), scanned MSB first
    localparam int unsigned INV_EXP_BITS = P_WIDTH;
    localparam logic [INV_EXP_BITS-1:0] INV_EXP = INV_EXP_BITS'(P_MOD - 8'd2);

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    typedef enum logic [1:0] {IDLE, KICK, WAIT, OUT} chain_state_t;

    function automatic logic [P_WIDTH-1:0] mod_add(input logic [P_WIDTH-1:0] a,
                                                   input logic [P_WIDTH-1:0] b);
        logic [P_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
        return s[P_WIDTH-1:0];
    endfunction

    function automatic logic [P_WIDTH-1:0] mod_sub(input logic [P_WIDTH-1:0] a,
                                                   input logic [P_WIDTH-1:0] b);
        if (a >= b) return a - b;
        return a + (P_MOD - b);
    endfunction

    function automatic logic [P_WIDTH-1:0] mod_mul(input logic [P_WIDTH-1:0] a,
                                                   input logic [P_WIDTH-1:0] b);
        logic [2*P_WIDTH-1:0] prod;
        prod = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
        return P_WIDTH'(prod % {{P_WIDTH{1'b0}}, P_MOD});
    endfunction

endpackage

// File: rtl/point_double_chain_point_double.sv
// Affine point doubler over GF(P_MOD); fixed latency of INV_EXP_BITS+1 edges
// from the last reset edge to Done. P must stay stable until Done.
module point_double
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    output logic         Done,
    output curve_point_t R
);

    localparam int unsigned STEP_W = $clog2(INV_EXP_BITS + 1);

    logic [STEP_W-1:0]       step;
    logic [INV_EXP_BITS-1:0] exp_sr;
    logic [P_WIDTH-1:0]      inv, inv_sq, inv_next, two_y;
    logic [P_WIDTH-1:0]      x_sq, num, lam, x3, y3;

    always_comb begin
        two_y    = mod_add(P.y, P.y);
        inv_sq   = mod_mul(inv, inv);
        inv_next = exp_sr[INV_EXP_BITS-1] ? mod_mul(inv_sq, two_y) : inv_sq;
        x_sq     = mod_mul(P.x, P.x);
        num      = mod_add(mod_add(x_sq, x_sq), mod_add(x_sq, CURVE_A));
        lam      = mod_mul(num, inv);
        x3       = mod_sub(mod_mul(lam, lam), mod_add(P.x, P.x));
        y3       = mod_sub(mod_mul(lam, mod_sub(P.x, x3)), P.y);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            step   <= '0;
            exp_sr <= INV_EXP;
            inv    <= P_WIDTH'(1);
            Done   <= 1'b0;
            R      <= '0;
        end else if (!Done) begin
            if (step != STEP_W'(INV_EXP_BITS)) begin
                inv    <= inv_next;
                exp_sr <= exp_sr << 1;
                step   <= step + STEP_W'(1);
            end else begin
                R.x  <= x3;
                R.y  <= y3;
                Done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/point_double_chain.sv
// Computes R = (2^k)*P by re-kicking one point_double k times.
// Optional macro POINT_INF_CHECK_EN: (0,0) is infinity, y==0 short-circuits to it.
module point_double_chain
    import elliptic_curve_structs::*;
#(
    parameter int unsigned K_WIDTH = 4
)
(
    input  logic               clk,
    input  logic               Reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  curve_point_t       P,
    input  logic [K_WIDTH-1:0] k,
    output logic               out_valid,
    input  logic               out_ready,
    output curve_point_t       R,
    output logic               busy
);

    chain_state_t       state, state_next;
    curve_point_t       acc, dbl_r;
    logic [K_WIDTH-1:0] cnt, cnt_dec;
    logic               first_wait, dbl_reset, dbl_done, dbl_fire, more_left;
    logic               inf_in, inf_dbl;

`ifdef POINT_INF_CHECK_EN
    assign inf_in  = (P.y == '0);
    assign inf_dbl = (dbl_r.y == '0);
`else
    assign inf_in  = 1'b0;
    assign inf_dbl = 1'b0;
`endif

    assign cnt_dec   = cnt - K_WIDTH'(1);
    assign more_left = (cnt_dec != '0);
    // Done is stale in KICK and the first WAIT cycle, so it only counts afterwards
    assign dbl_fire  = (state == WAIT) && dbl_done && !first_wait;

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (k != '0 && !inf_in) ? KICK : OUT;
            KICK: state_next = WAIT;
            WAIT: if (dbl_fire) state_next = (more_left && !inf_dbl) ? KICK : OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == OUT);
        dbl_reset = (state == KICK);
        R         = acc;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            acc        <= '0;
            cnt        <= '0;
            first_wait <= 1'b0;
        end else begin
            first_wait <= (state == KICK);
            if (state == IDLE && in_valid) begin
                acc <= (k != '0 && inf_in) ? curve_point_t'('0) : P;
                cnt <= k;
            end else if (dbl_fire) begin
                acc <= (more_left && inf_dbl) ? curve_point_t'('0) : dbl_r;
                cnt <= cnt_dec;
            end
        end
    end

    point_double u_point_double (
        .clk   (clk),
        .Reset (Reset | dbl_reset),
        .P     (acc),
        .Done  (dbl_done),
        .R     (dbl_r)
    );

endmodule

// File: tb/tb_point_double_chain.sv
// Self-checking bench for point_double_chain against an integer GF(251) model.
module tb_point_double_chain;
    import elliptic_curve_structs::*;

    localparam int KW     = 4;
    localparam int LAT    = 9;      // doubler: edges from last reset edge to Done
    localparam int PM     = 251;
    localparam int CA     = 2;
    localparam int CB     = 3;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic Reset, in_valid, in_ready, out_valid, out_ready, busy;
    curve_point_t P, R;
    logic [KW-1:0] k;

    int passed = 0;
    int total  = 0;
    int kicks_seen = 0;
    curve_point_t pts[$];
    curve_point_t G, G2, G8;

    typedef struct {
        string        name;
        curve_point_t p;
        int           k;
        curve_point_t exp_r;
        int           exp_lat;
        int           exp_kicks;
    } vec_t;
    vec_t vecs[$];

    point_double_chain #(.K_WIDTH(KW)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .k         (k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.dbl_reset) kicks_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic int md(input int v);
        return ((v % PM) + PM) % PM;
    endfunction

    function automatic int inv_mod(input int d);
        for (int z = 1; z < PM; z++) if (md(d * z) == 1) return z;
        return 0;
    endfunction

    function automatic curve_point_t dbl_pt(input curve_point_t p);
        curve_point_t q;
        int x, y, lam, x3, y3;
        x   = int'(p.x);
        y   = int'(p.y);
        lam = md(md(3 * x * x + CA) * inv_mod(md(2 * y)));
        x3  = md(lam * lam - 2 * x);
        y3  = md(lam * (x - x3) - y);
        q.x = 8'(x3);
        q.y = 8'(y3);
        return q;
    endfunction

    // Returns 0 when the chain would double a y==0 point and no infinity handling exists
    function automatic bit ref_chain(input curve_point_t p, input int kk,
                                     output curve_point_t r, output int nd);
        r  = p;
        nd = 0;
        for (int i = 0; i < kk; i++) begin
            if (r.y == 0) begin
`ifdef POINT_INF_CHECK_EN
                r = '0;
                return 1'b1;
`else
                return 1'b0;
`endif
            end
            r = dbl_pt(r);
            nd++;
        end
        return 1'b1;
    endfunction

    task automatic add_vec(input string name, input curve_point_t p, input int kk);
        vec_t v;
        int nd;
        void'(ref_chain(p, kk, v.exp_r, nd));
        v.name      = name;
        v.p         = p;
        v.k         = kk;
        v.exp_lat   = nd * (LAT + 2) + 1;
        v.exp_kicks = nd;
        vecs.push_back(v);
    endtask

    // One job from IDLE; out_ready stays low for 'hold' OUT cycles before acceptance
    task automatic run_job(input curve_point_t p, input int kk, input int hold,
                           output curve_point_t r, output int lat, output int kicks);
        int k0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        P = p;
        k = KW'(kk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        k0 = kicks_seen;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < BUDGET) begin
            in_valid = 1'($urandom);
            P.x = 8'($urandom);
            P.y = 8'($urandom);
            k   = KW'($urandom);
            check("busy_in_ready", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", out_valid, 1);
        r = R;
        kicks = kicks_seen - k0;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_R", R, r);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
    endtask

    initial begin
        curve_point_t r, jp[2], tmp;
        int lat, kicks, nd, jk[2], n_acc;
        bit found, saw_valid;
        curve_point_t res[$];

        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; P = '0; k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_R", R, 0);
        Reset = 1'b0;

        for (int x = 0; x < PM; x++)
            for (int y = 1; y < PM; y++)
                if (md(y * y) == md(x * x * x + CA * x + CB)) begin
                    tmp.x = 8'(x);
                    tmp.y = 8'(y);
                    pts.push_back(tmp);
                end

        found = 1'b0;
        foreach (pts[i]) if (!found && ref_chain(pts[i], 15, tmp, nd) && nd == 15) begin
            G = pts[i];
            found = 1'b1;
        end
        if (!found) begin
            $display("FAIL gen_point: actual none required one");
            $fatal(1, "no usable base point");
        end
        G2 = dbl_pt(G);
        void'(ref_chain(G, 3, G8, nd));

        add_vec("k0_G",   G,  0);
        add_vec("k1_G",   G,  1);
        add_vec("k3_G",   G,  3);
        add_vec("k2_2G",  G2, 2);
        add_vec("k15_G",  G,  15);
        add_vec("k1_8G",  G8, 1);

        foreach (vecs[i]) begin
            run_job(vecs[i].p, vecs[i].k, 0, r, lat, kicks);
            check({vecs[i].name, "_R"}, r, vecs[i].exp_r);
            check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, "_kicks"}, kicks, vecs[i].exp_kicks);
        end

        // backpressure: 5 stalled OUT cycles, accepted in the 6th
        run_job(G, 1, 5, r, lat, kicks);
        check("bp_R", r, G2);

        // reset during the second WAIT cycle of a k=2 job
        @(negedge clk);
        P = G; k = KW'(2); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_R", R, 0);
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw_valid |= out_valid;
        end
        check("mid_rst_no_result", saw_valid, 0);
        run_job(G, 1, 0, r, lat, kicks);
        check("post_rst_R", r, G2);

`ifdef POINT_INF_CHECK_EN
        run_job(curve_point_t'('0), 5, 0, r, lat, kicks);
        check("inf_R", r, 0);
        check("inf_lat", lat, 1);
        check("inf_kicks", kicks, 0);
`endif

        // back-to-back with in_valid held high
        jp[0] = G;  jk[0] = 1;
        jp[1] = G2; jk[1] = 2;
        @(negedge clk);
        out_ready = 1'b1;
        P = jp[0]; k = KW'(jk[0]); in_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) res.push_back(R);
            if (in_ready && in_valid) n_acc++;
            else if (n_acc < 2) begin
                P = jp[n_acc];
                k = KW'(jk[n_acc]);
            end else in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_results", res.size(), 2);
        if (res.size() >= 1) check("b2b_first", res[0], G2);
        if (res.size() >= 2) check("b2b_second", res[1], G8);

        for (int j = 0; j < 12; j++) begin
            curve_point_t rp, exp_r;
            int rk, tries;
            tries = 0;
            do begin
                rp = pts[$urandom_range(0, pts.size() - 1)];
                rk = $urandom_range(0, 15);
                tries++;
            end while (!ref_chain(rp, rk, exp_r, nd) && tries < 50);
            if (tries < 50) begin
                run_job(rp, rk, $urandom_range(0, 3), r, lat, kicks);
                check("rnd_R", r, exp_r);
                check("rnd_lat", lat, nd * (LAT + 2) + 1);
                check("rnd_kicks", kicks, nd);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
